// File: rtl/map_store.sv
// map_store: flop-based tile map with a reset-time default fill and a vsync-gated one-entry edit buffer
module map_store #(
  parameter int MAP_SIZE_BITS = 4,
  parameter int VAL_BITS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic [MAP_SIZE_BITS-1:0] map_col,
  input  logic [MAP_SIZE_BITS-1:0] map_row,
  output logic [VAL_BITS-1:0]      map_val,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [MAP_SIZE_BITS-1:0] wr_col,
  input  logic [MAP_SIZE_BITS-1:0] wr_row,
  input  logic [VAL_BITS-1:0]      wr_val,
  output logic                     init_done
);
  localparam int N = 1 << (2 * MAP_SIZE_BITS);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [2*MAP_SIZE_BITS-1:0] cnt;
  logic [MAP_SIZE_BITS-1:0] b_col, b_row, f_col, f_row;
  logic [VAL_BITS-1:0] b_val, f_val, w_val;
  logic [2*MAP_SIZE_BITS-1:0] w_idx;
  logic pend, we;
  logic [VAL_BITS-1:0] mem [N];
  assign f_col = cnt[MAP_SIZE_BITS-1:0];
  assign f_row = cnt[2*MAP_SIZE_BITS-1:MAP_SIZE_BITS];
  always_comb begin
    f_val = (f_col == '0 || f_row == '0 || f_col == '1 || f_row == '1) ? VAL_BITS'(1) :
            (f_col[1:0] == 2'd2 && f_row[1:0] == 2'd2) ? VAL_BITS'(2) : '0;
    we = !reset && (state == INIT || (pend && vsync));
    w_idx = (state == INIT) ? cnt : {b_row, b_col};
    w_val = (state == INIT) ? f_val : b_val;
  end
  assign wr_ready = init_done && !pend;
  assign map_val = init_done ? mem[{map_row, map_col}] : VAL_BITS'(1);
  always_ff @(posedge clk) if (we) mem[w_idx] <= w_val;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      pend <= 1'b0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) begin
        state <= RUN;
        init_done <= 1'b1;
      end
    end else if (pend && vsync) begin
      pend <= 1'b0;
    end else if (wr_valid && wr_ready) begin
      b_col <= wr_col;
      b_row <= wr_row;
      b_val <= wr_val;
      pend <= 1'b1;
    end
  end
endmodule
